// File: rtl/thiele_receipt_pkg.sv
// Shared definitions for the receipt generator and checker: opcodes, error
// codes, the single mu-cost function, receipt layout and FSM state encoding.
package thiele_receipt_pkg;

    // Opcodes 0x00-0x10 are arithmetic-cost instructions; 0x11 is HALT.
    localparam logic [7:0] OP_00   = 8'h00;
    localparam logic [7:0] OP_01   = 8'h01;
    localparam logic [7:0] OP_02   = 8'h02;
    localparam logic [7:0] OP_03   = 8'h03;
    localparam logic [7:0] OP_04   = 8'h04;
    localparam logic [7:0] OP_05   = 8'h05;
    localparam logic [7:0] OP_06   = 8'h06;
    localparam logic [7:0] OP_07   = 8'h07;
    localparam logic [7:0] OP_08   = 8'h08;
    localparam logic [7:0] OP_09   = 8'h09;
    localparam logic [7:0] OP_0A   = 8'h0A;
    localparam logic [7:0] OP_0B   = 8'h0B;
    localparam logic [7:0] OP_0C   = 8'h0C;
    localparam logic [7:0] OP_0D   = 8'h0D;
    localparam logic [7:0] OP_0E   = 8'h0E;
    localparam logic [7:0] OP_0F   = 8'h0F;
    localparam logic [7:0] OP_10   = 8'h10;
    localparam logic [7:0] OP_HALT = 8'h11;

    // Error codes; 1 and 2 are raised only by the checker.
    localparam logic [31:0] ERR_NONE     = 32'd0;
    localparam logic [31:0] ERR_CHAIN    = 32'd1;
    localparam logic [31:0] ERR_MU       = 32'd2;
    localparam logic [31:0] ERR_OPCODE   = 32'd3;
    localparam logic [31:0] ERR_OVERFLOW = 32'd4;

    localparam int unsigned RCPT_W = 136;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StHalted = 2'd1,
        StFault  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] seq;
        logic [31:0] pre_mu;
        logic [31:0] post_mu;
        logic [7:0]  opcode;
        logic [31:0] operand;
    } receipt_t;

    typedef struct packed {
        logic        known;
        logic [31:0] cost;
    } cost_t;

    // The one definition of mu-cost shared by generator and checker.
    function automatic cost_t op_cost(input logic [7:0] opcode, input logic [31:0] operand);
        cost_t r;
        r.known = 1'b1;
        r.cost  = operand;
        if (opcode == OP_HALT) begin
            r.cost = '0;
        end else if (opcode > OP_10) begin
            r.known = 1'b0;
            r.cost  = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/receipt_fifo.sv
// Synchronous show-ahead FIFO holding packed receipts; rdata is the head entry.
module receipt_fifo
    import thiele_receipt_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [RCPT_W-1:0] wdata,
    input  logic              pop,
    output logic [RCPT_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [RCPT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset since empty gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/receipt_generator.sv
// Turns retired instructions into chained mu receipts and queues them for the sink.
module receipt_generator
    import thiele_receipt_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mu_load,
    input  logic [31:0] mu_init,
    input  logic        retire_valid,
    output logic        retire_ready,
    input  logic [7:0]  retire_opcode,
    input  logic [31:0] retire_operand,
    output logic        rcpt_valid,
    input  logic        rcpt_ready,
    output logic [31:0] rcpt_seq,
    output logic [31:0] rcpt_pre_mu,
    output logic [31:0] rcpt_post_mu,
    output logic [7:0]  rcpt_opcode,
    output logic [31:0] rcpt_operand,
    output logic [31:0] mu_total,
    output logic        halted,
    output logic        fault,
    output logic [31:0] error_code,
    input  logic        clear_fault,
    output logic [AW:0] fifo_count
);

    state_t      state;
    state_t      state_next;
    logic [31:0] mu_q;
    logic [31:0] seq_q;
    logic [31:0] err_q;
    cost_t       cost;
    logic [32:0] sum;
    logic        overflow;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    receipt_t    wr_rcpt;
    receipt_t    head;

    assign cost     = op_cost(retire_opcode, retire_operand);
    // 33-bit sum so a carry out flags overflow rather than wrapping.
    assign sum      = {1'b0, mu_q} + {1'b0, cost.cost};
    assign overflow = sum[32];
    assign accept   = retire_valid && retire_ready;
    assign push     = accept && cost.known && !overflow;
    assign pop      = rcpt_valid && rcpt_ready;

    assign wr_rcpt = '{
        seq:     seq_q,
        pre_mu:  mu_q,
        post_mu: sum[31:0],
        opcode:  retire_opcode,
        operand: retire_operand
    };

    receipt_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .wdata(wr_rcpt),
        .pop  (pop),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StRun;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: bad instructions fault, HALT parks until reset.
    always_comb begin
        state_next = state;
        unique case (state)
            StRun: begin
                if (accept) begin
                    if (!cost.known || overflow) begin
                        state_next = StFault;
                    end else if (retire_opcode == OP_HALT) begin
                        state_next = StHalted;
                    end
                end
            end
            StFault: begin
                if (clear_fault) begin
                    state_next = StRun;
                end
            end
            StHalted: begin
                state_next = StHalted;
            end
            default: begin
                state_next = StRun;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        retire_ready = (state == StRun) && !fifo_full;
        halted       = (state == StHalted);
        fault        = (state == StFault);
    end

    // Accumulator, sequence and error code; only a pushed receipt advances mu/seq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mu_q  <= '0;
            seq_q <= '0;
            err_q <= ERR_NONE;
        end else begin
            if (push) begin
                mu_q  <= sum[31:0];
                seq_q <= seq_q + 32'd1;
            end else if (mu_load && fifo_empty && !accept) begin
                mu_q <= mu_init;
            end
            if (accept && !cost.known) begin
                err_q <= ERR_OPCODE;
            end else if (accept && overflow) begin
                err_q <= ERR_OVERFLOW;
            end else if (clear_fault) begin
                err_q <= ERR_NONE;
            end
        end
    end

    // Head fields read as zero when nothing is queued.
    always_comb begin
        rcpt_valid   = !fifo_empty;
        rcpt_seq     = rcpt_valid ? head.seq     : '0;
        rcpt_pre_mu  = rcpt_valid ? head.pre_mu  : '0;
        rcpt_post_mu = rcpt_valid ? head.post_mu : '0;
        rcpt_opcode  = rcpt_valid ? head.opcode  : '0;
        rcpt_operand = rcpt_valid ? head.operand : '0;
        mu_total     = mu_q;
        error_code   = err_q;
    end

endmodule

// File: doc/receipt_generator.md
Name: receipt_generator

Overview:
Transmit-side counterpart of the receipt integrity checker. It accepts retired instructions, computes their μ-cost from the shared cost table, and keeps the running μ accumulator. For each instruction it emits a chain-consistent receipt {seq, pre_mu, post_mu, opcode, operand} through a buffered valid/ready stream. It sits between the core retire stage and the receipt sink or checker; every emitted receipt satisfies post_mu = pre_mu + cost, and each receipt's pre_mu equals the previous receipt's post_mu.

Parameters:
DEPTH, 8, receipt FIFO entries (power of 2, ≥2)
AW, 3, log2(DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
mu_load  in  1  pulse: load accumulator from mu_init (honoured only when FIFO empty and not retiring)
mu_init  in  32  initial μ value
retire_valid  in  1  retired instruction present
retire_ready  out  1  generator accepts instruction
retire_opcode  in  8  opcode
retire_operand  in  32  operand
rcpt_valid  out  1  receipt at FIFO head
rcpt_ready  in  1  sink consumes receipt
rcpt_seq  out  32  receipt sequence number
rcpt_pre_mu  out  32  μ before instruction
rcpt_post_mu  out  32  μ after instruction
rcpt_opcode  out  8  opcode
rcpt_operand  out  32  operand
mu_total  out  32  current accumulator
halted  out  1  HALT receipt generated
fault  out  1  sticky fault
error_code  out  32  0 none, 3 unknown opcode, 4 overflow
clear_fault  in  1  pulse: clear fault and error_code, return to RUN
fifo_count  out  AW+1  occupancy

Behaviour:
- Reset state: FSM = RUN, mu_total = 0, seq = 0, FIFO empty. All outputs 0, except retire_ready = 1 once out of reset.
- Cost: opcodes 0x00–0x10 give cost = operand. 0x11 (HALT) gives cost 0. Any other opcode is unknown.
- retire_ready = (state == RUN) && (fifo_count < DEPTH). An instruction is accepted when retire_valid && retire_ready.
- Valid accept at edge N: receipt {seq, mu_total, mu_total + cost, opcode, operand} is written to the FIFO; mu_total += cost; seq += 1. rcpt_valid is high after edge N, so latency is 1 cycle when the FIFO is empty. There is no combinational bypass.
- Overflow: if mu_total + cost > 2^32−1 (use a 33-bit sum), the instruction is consumed and no receipt is written. mu_total and seq stay unchanged, error_code = 4, fault = 1, state = FAULT.
- Unknown opcode: the instruction is consumed and no receipt is written. mu_total and seq stay unchanged, error_code = 3, state = FAULT.
- HALT: the receipt is written normally, halted = 1, state = HALTED, and retire_ready = 0 from then on. Only reset leaves HALTED.
- FAULT: retire_ready = 0. clear_fault returns to RUN and sets error_code = 0. Queued receipts keep draining throughout.
- FIFO: show-ahead; rcpt_* reflect the head entry whenever rcpt_valid = 1. A pop occurs when rcpt_valid && rcpt_ready. A simultaneous push and pop leaves the count unchanged. A pop when empty is ignored. Pointers are AW bits wide and wrap modulo DEPTH.
- rcpt_* must hold stable while rcpt_valid && !rcpt_ready.
- mu_load is ignored when FIFO is non-empty or an accept occurs the same cycle. Otherwise it sets mu_total = mu_init; seq is not reset.
- seq wraps from 2^32−1 to 0.
- Asserting rst_n low mid-stream discards all queued receipts immediately; all state returns to reset values.

Decomposition:
- Package thiele_receipt_pkg holds:
  - opcode localparams 0x00–0x11
  - error codes (0/1/2/3/4, shared with the checker)
  - the cost function, as a single shared definition
  - FSM state encodings RUN/HALTED/FAULT
- Sub-module receipt_fifo: synchronous show-ahead FIFO, width 136 (32+32+32+8+32), parameter DEPTH, with push/pop/full/empty/count.

Test Plan:
1. Reset, then retire {0x00, 10}, {0x05, 7}, {0x11, 0} with rcpt_ready = 1 → receipts (seq 0, 0→10), (seq 1, 10→17), (seq 2, 17→17, op 0x11); halted = 1; retire_ready = 0.
2. mu_load with mu_init = 0xFFFFFFF0, then retire {0x03, 0x20} → no receipt, error_code = 4, fault = 1, mu_total stays 0xFFFFFFF0. Then clear_fault followed by {0x03, 0x0F} → receipt 0xFFFFFFF0→0xFFFFFFFF.
3. Retire opcode 0x42 → consumed, no receipt, error_code = 3, seq unchanged, retire_ready = 0 until clear_fault.
4. rcpt_ready = 0, retire 9 back-to-back cost-1 instructions (DEPTH = 8) → 8 accepted, retire_ready = 0, fifo_count = 8, head stable. Then release rcpt_ready → 9 receipts chained 0→1→…→9 in order.
5. Simultaneous push and pop with count = 3 over 20 cycles → count stays 3; every consecutive pair satisfies post_mu(n) = pre_mu(n+1).
6. Assert rst_n low with 5 queued receipts → rcpt_valid = 0, fifo_count = 0, mu_total = 0 asynchronously; the first post-reset receipt has seq 0.
